// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: redirect recovery, multi-cycle mult/div
// occupancy of E, and cache/ROB/IQ/free-list back-pressure.
//
// state   | meaning
// INIT    | first cycle after reset, full flush of every stage
// RUN     | normal operation, prioritised stall sources
// RECOVER | rename map / free list restore after a redirect
module pipe_ctrl #(
  parameter int MULT_CYCLES    = 2,
  parameter int DIV_CYCLES     = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_stall,
  input  logic d_stall,
  input  logic rob_full,
  input  logic iq_full,
  input  logic freelist_empty,
  input  logic exception_valid,
  input  logic branch_taken,
  input  logic md_start,
  input  logic md_is_div,
  output logic stallF,
  output logic stallD,
  output logic stallR,
  output logic stallI,
  output logic stallE,
  output logic stallC,
  output logic flushF,
  output logic flushD,
  output logic flushR,
  output logic flushI,
  output logic flushE,
  output logic flushC,
  output logic recovering,
  output logic md_busy
);

  localparam int RC_W = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);
  localparam logic [5:0]      MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0]      DIV_LOAD  = 6'(DIV_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_LOAD   = RC_W'(RECOVER_CYCLES);

  typedef enum logic [1:0] {INIT, RUN, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [5:0]      md_cnt, md_cnt_nxt;
  logic [RC_W-1:0] rc_cnt, rc_cnt_nxt;
  logic            redirect;
  logic [5:0]      run_stall, run_flush;
  logic [5:0]      stall_v, flush_v;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= INIT;
      md_cnt <= '0;
      rc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      rc_cnt <= rc_cnt_nxt;
    end
  end

  assign redirect = (exception_valid | branch_taken) && (state != INIT);
  assign md_busy  = (md_cnt != 6'd0);

  // Vectors are ordered F,D,R,I,E,C from bit 5 down to bit 0.
  always_comb begin
    run_stall = 6'b000000;
    run_flush = 6'b000000;
    if (d_stall) begin
      run_stall = 6'b111111;
    end else if (md_busy) begin
      run_stall = 6'b111110;
      run_flush = 6'b000001;
    end else if (rob_full | iq_full | freelist_empty) begin
      run_stall = 6'b111000;
      run_flush = 6'b000100;
    end else if (i_stall) begin
      run_stall = 6'b100000;
      run_flush = 6'b010000;
    end
  end

  always_comb begin
    state_nxt  = state;
    rc_cnt_nxt = rc_cnt;
    stall_v    = 6'b000000;
    flush_v    = 6'b000000;
    case (state)
      INIT: begin
        flush_v   = 6'b111111;
        state_nxt = RUN;
      end
      RUN: begin
        stall_v = run_stall;
        flush_v = run_flush;
      end
      RECOVER: begin
        // D and R held empty while the rename map is restored; older work in I/E/C drains.
        stall_v = {i_stall, 2'b00, run_stall[2:0]};
        flush_v = {1'b0, 2'b11, run_flush[2:0]};
        if (rc_cnt <= RC_W'(1)) begin
          state_nxt  = RUN;
          rc_cnt_nxt = '0;
        end else begin
          rc_cnt_nxt = rc_cnt - RC_W'(1);
        end
      end
      default: state_nxt = INIT;
    endcase
    if (redirect) begin
      stall_v    = 6'b000000;
      flush_v    = 6'b111111;
      state_nxt  = RECOVER;
      rc_cnt_nxt = RC_LOAD;
    end
  end

  always_comb begin
    md_cnt_nxt = md_cnt;
    if (redirect)
      md_cnt_nxt = 6'd0;
    else if (md_busy)
      md_cnt_nxt = md_cnt - 6'd1;
    else if (md_start)
      md_cnt_nxt = md_is_div ? DIV_LOAD : MULT_LOAD;
  end

  assign {stallF, stallD, stallR, stallI, stallE, stallC} = stall_v;
  assign {flushF, flushD, flushR, flushI, flushE, flushC} = flush_v;
  assign recovering = (state == RECOVER);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with default parameters; every cycle's full
// output vector is compared against a hand-computed constant.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic resetn;
  logic i_stall, d_stall, rob_full, iq_full, freelist_empty;
  logic exception_valid, branch_taken, md_start, md_is_div;
  logic stallF, stallD, stallR, stallI, stallE, stallC;
  logic flushF, flushD, flushR, flushI, flushE, flushC;
  logic recovering, md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .resetn(resetn),
    .i_stall(i_stall), .d_stall(d_stall), .rob_full(rob_full),
    .iq_full(iq_full), .freelist_empty(freelist_empty),
    .exception_valid(exception_valid), .branch_taken(branch_taken),
    .md_start(md_start), .md_is_div(md_is_div),
    .stallF(stallF), .stallD(stallD), .stallR(stallR),
    .stallI(stallI), .stallE(stallE), .stallC(stallC),
    .flushF(flushF), .flushD(flushD), .flushR(flushR),
    .flushI(flushI), .flushE(flushE), .flushC(flushC),
    .recovering(recovering), .md_busy(md_busy)
  );

  // {stall F..C, flush F..C, recovering, md_busy}
  logic [13:0] obs;
  assign obs = {stallF, stallD, stallR, stallI, stallE, stallC,
                flushF, flushD, flushR, flushI, flushE, flushC,
                recovering, md_busy};

  localparam logic [13:0] V_IDLE   = 14'b000000_000000_0_0;
  localparam logic [13:0] V_FLUSH  = 14'b000000_111111_0_0;
  localparam logic [13:0] V_FLBUSY = 14'b000000_111111_0_1;
  localparam logic [13:0] V_FLREC  = 14'b000000_111111_1_0;
  localparam logic [13:0] V_MD     = 14'b111110_000001_0_1;
  localparam logic [13:0] V_DST    = 14'b111111_000000_0_0;
  localparam logic [13:0] V_DSTMD  = 14'b111111_000000_0_1;
  localparam logic [13:0] V_BP     = 14'b111000_000100_0_0;
  localparam logic [13:0] V_IM     = 14'b100000_010000_0_0;
  localparam logic [13:0] V_REC    = 14'b000000_011000_1_0;
  localparam logic [13:0] V_RECIM  = 14'b100000_011000_1_0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs set before the call apply to this cycle; sample at negedge, then advance.
  task automatic cyc(input string tag, input logic [13:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {i_stall, d_stall, rob_full, iq_full, freelist_empty} = '0;
    {exception_valid, branch_taken, md_start, md_is_div} = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_held", obs, V_FLUSH);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc("init", V_FLUSH);
    cyc("run_idle", V_IDLE);

    // divide: busy for DIV_CYCLES-1 cycles, a second md_start mid-way is ignored
    md_start = 1'b1; md_is_div = 1'b1;
    cyc("div_start", V_IDLE);
    md_start = 1'b0; md_is_div = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      md_start = (i == 10);
      cyc($sformatf("div_busy%0d", i), V_MD);
    end
    md_start = 1'b0;
    cyc("div_done", V_IDLE);

    // multiply: one busy cycle
    md_start = 1'b1;
    cyc("mul_start", V_IDLE);
    md_start = 1'b0;
    cyc("mul_busy", V_MD);
    cyc("mul_done", V_IDLE);

    // multiply overlapped with d_stall still counts down
    md_start = 1'b1;
    cyc("mul2_start", V_IDLE);
    md_start = 1'b0; d_stall = 1'b1;
    cyc("mul2_dstall", V_DSTMD);
    d_stall = 1'b0;
    cyc("mul2_done", V_IDLE);

    // redirect in the 5th busy cycle of a divide
    md_start = 1'b1; md_is_div = 1'b1;
    cyc("div2_start", V_IDLE);
    md_start = 1'b0; md_is_div = 1'b0;
    for (int i = 1; i <= 4; i++) cyc("div2_busy", V_MD);
    branch_taken = 1'b1;
    cyc("redir_flush", V_FLBUSY);
    branch_taken = 1'b0;
    cyc("recover1", V_REC);
    i_stall = 1'b1;
    cyc("recover2_imiss", V_RECIM);
    i_stall = 1'b0;
    cyc("post_recover", V_IDLE);

    // priority: d_stall over back-pressure
    d_stall = 1'b1; rob_full = 1'b1;
    cyc("prio_dstall", V_DST);
    d_stall = 1'b0;
    cyc("prio_robfull", V_BP);
    rob_full = 1'b0; freelist_empty = 1'b1;
    cyc("prio_freelist", V_BP);
    freelist_empty = 1'b0;
    cyc("prio_clear", V_IDLE);

    // i-miss for exactly 3 cycles
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("imiss", V_IM);
    i_stall = 1'b0;
    cyc("imiss_clear", V_IDLE);

    // double redirect: both pulses together, then another one cycle into RECOVER
    exception_valid = 1'b1; branch_taken = 1'b1;
    cyc("dbl_redir1", V_FLUSH);
    branch_taken = 1'b0;
    cyc("dbl_redir2", V_FLREC);
    exception_valid = 1'b0;
    cyc("dbl_rec1", V_REC);
    cyc("dbl_rec2", V_REC);
    cyc("dbl_run", V_IDLE);

    // asynchronous reset mid-divide
    md_start = 1'b1; md_is_div = 1'b1;
    cyc("div3_start", V_IDLE);
    md_start = 1'b0; md_is_div = 1'b0;
    cyc("div3_busy", V_MD);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", obs, V_FLUSH);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc("reinit", V_FLUSH);
    cyc("reinit_run", V_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
